button_debounce: RTL

- Input-side companion to the board LED drivers. Takes one raw, bouncing push-button pin and produces a clean debounced level plus one-cycle event ticks.
- Events: press, release, and long-press (one per hold).
- Sits between the board button pin and user logic, e.g. a blink-rate or mode selector. All outputs are registered in the clk domain.

---
 rtl/button_debounce.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/button_debounce.sv
// button_debounce
// Turns one raw, bouncing push-button pin into a clean debounced level plus
// one-cycle press, release and long-press event ticks. Every output is a
// flop in the clk domain.
//
// Ports:
//   clk          system clock, all logic on its rising edge
//   reset        synchronous, active-high reset
//   btn          raw asynchronous button pin, high while pressed
//   level        debounced button state
//   press_tick   one-cycle pulse when a press is accepted
//   release_tick one-cycle pulse when a release is accepted
//   long_tick    one-cycle pulse once per press held for N_LONG+1 cycles
//
// Parameters:
//   N_DEBOUNCE   stable-sample count minus 1 needed to accept a level change
//   N_LONG       hold count minus 1, after an accepted press, before long_tick
module button_debounce #(
  parameter logic [31:0] N_DEBOUNCE = 32'd1_999_999,
  parameter logic [31:0] N_LONG     = 32'd99_999_999
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic press_tick,
  output logic release_tick,
  output logic long_tick
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  logic        s1;
  logic        s2;
  state_t      state;
  state_t      state_n;
  logic [31:0] deb_cnt;
  logic [31:0] deb_cnt_n;
  logic [31:0] hold_cnt;
  logic [31:0] hold_cnt_n;
  logic        long_done;
  logic        long_done_n;
  logic        level_n;
  logic        press_tick_n;
  logic        release_tick_n;
  logic        long_tick_n;

  // Stage: two-flop synchroniser, the only path from the pin into the FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Stage: debounce / long-press next-state logic
  always_comb begin
    state_n        = state;
    deb_cnt_n      = deb_cnt;
    hold_cnt_n     = hold_cnt;
    long_done_n    = long_done;
    level_n        = level;
    press_tick_n   = 1'b0;
    release_tick_n = 1'b0;
    long_tick_n    = 1'b0;

    case (state)
      IDLE_LOW: begin
        if (s2) begin
          state_n   = WAIT_HIGH;
          deb_cnt_n = 32'd0;
        end
      end
      WAIT_HIGH: begin
        if (!s2) begin
          state_n = IDLE_LOW;
        end else if (deb_cnt == N_DEBOUNCE) begin
          state_n      = HIGH;
          level_n      = 1'b1;
          press_tick_n = 1'b1;
          hold_cnt_n   = 32'd0;
          long_done_n  = 1'b0;
        end else begin
          deb_cnt_n = deb_cnt + 32'd1;
        end
      end
      HIGH: begin
        if (!s2) begin
          state_n   = WAIT_LOW;
          deb_cnt_n = 32'd0;
        end
      end
      WAIT_LOW: begin
        // A high sample here is a release bounce: level and hold_cnt carry on.
        if (s2) begin
          state_n = HIGH;
        end else if (deb_cnt == N_DEBOUNCE) begin
          state_n        = IDLE_LOW;
          level_n        = 1'b0;
          release_tick_n = 1'b1;
        end else begin
          deb_cnt_n = deb_cnt + 32'd1;
        end
      end
      default: state_n = IDLE_LOW;
    endcase

    // Hold timing keeps running through release bounces; it freezes once the
    // single long_tick for this press has fired.
    if ((state == HIGH) || (state == WAIT_LOW)) begin
      if (!long_done && (hold_cnt == N_LONG)) begin
        long_tick_n = 1'b1;
        long_done_n = 1'b1;
      end else if (!long_done) begin
        hold_cnt_n = hold_cnt + 32'd1;
      end
    end
  end

  // Stage: registered state and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE_LOW;
      deb_cnt      <= 32'd0;
      hold_cnt     <= 32'd0;
      long_done    <= 1'b0;
      level        <= 1'b0;
      press_tick   <= 1'b0;
      release_tick <= 1'b0;
      long_tick    <= 1'b0;
    end else begin
      state        <= state_n;
      deb_cnt      <= deb_cnt_n;
      hold_cnt     <= hold_cnt_n;
      long_done    <= long_done_n;
      level        <= level_n;
      press_tick   <= press_tick_n;
      release_tick <= release_tick_n;
      long_tick    <= long_tick_n;
    end
  end

endmodule
